// File: rtl/multi_stage_controller.sv
// multi_stage_controller: sequences N_STAGES datapath units with a start/release host handshake, per-stage watchdog, abort and sticky fault report.
//   clk, rst        : clock and asynchronous active-high reset
//   start           : host start level; arming while high, launch on release
//   abort           : synchronous abort back to IDLE (ignored in IDLE/FAULT)
//   timeout_limit   : max RUN cycles per stage, 0 disables the watchdog
//   stage_done      : per-stage done inputs, only the running stage's bit is used
//   stage_start     : one-hot single-cycle launch pulse
//   stage_idx       : current stage index
//   busy, all_done  : activity status and end-of-sequence pulse
//   err, err_stage  : sticky timeout flag and the stage that timed out
module multi_stage_controller #(
    parameter int N_STAGES = 4,
    parameter int TO_W = 16,
    localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [TO_W-1:0]     timeout_limit,
    input  logic [N_STAGES-1:0] stage_done,
    output logic [N_STAGES-1:0] stage_start,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                busy,
    output logic                all_done,
    output logic                err,
    output logic [IDX_W-1:0]    err_stage
);
    typedef enum logic [2:0] {IDLE, ARM, LAUNCH, RUN, FINISH, FAULT} state_t;
    state_t state, state_n;
    logic [IDX_W-1:0] cur, cur_n, err_stage_n;
    logic [TO_W-1:0] cnt, cnt_n;
    logic err_n, active, done_cur, last, timed_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cur <= '0;
            cnt <= '0;
            err <= 1'b0;
            err_stage <= '0;
        end else begin
            state <= state_n;
            cur <= cur_n;
            cnt <= cnt_n;
            err <= err_n;
            err_stage <= err_stage_n;
        end
    end

    assign active = (state == ARM) || (state == LAUNCH) || (state == RUN) || (state == FINISH);
    assign done_cur = stage_done[cur];
    assign last = cur == IDX_W'(N_STAGES - 1);
    assign timed_out = (timeout_limit != '0) && (cnt == timeout_limit - 1'b1);

    always_comb begin
        state_n = state;
        cur_n = cur;
        cnt_n = cnt;
        err_n = err;
        err_stage_n = err_stage;
        case (state)
            IDLE: begin
                state_n = start ? ARM : IDLE;
                cur_n = start ? '0 : cur;
            end
            ARM: state_n = start ? ARM : LAUNCH;
            LAUNCH: begin
                cnt_n = '0;
                state_n = RUN;
            end
            RUN: begin
                if (done_cur) begin
                    state_n = last ? FINISH : LAUNCH;
                    cur_n = last ? cur : cur + 1'b1;
                end else if (timed_out) begin
                    state_n = FAULT;
                    err_n = 1'b1;
                    err_stage_n = cur;
                end else begin
                    // Saturate so a disabled watchdog never wraps into a false match.
                    cnt_n = (&cnt) ? cnt : cnt + 1'b1;
                end
            end
            FINISH: begin
                state_n = IDLE;
                cur_n = '0;
            end
            FAULT: begin
                state_n = start ? ARM : FAULT;
                cur_n = start ? '0 : cur;
                err_n = start ? 1'b0 : err;
            end
            default: state_n = IDLE;
        endcase
        // Abort outranks everything in the active states but leaves the fault report alone.
        if (abort && active) begin
            state_n = IDLE;
            cur_n = '0;
            err_n = err;
            err_stage_n = err_stage;
        end
    end

    assign stage_start = (state == LAUNCH) ? (N_STAGES'(1) << cur) : '0;
    assign stage_idx = cur;
    assign busy = active;
    assign all_done = state == FINISH;
endmodule
